// File: rtl/hash_job_ctrl_pkg.sv
// Shared types and constants for the hashing-pipeline job controller.
package hash_job_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    localparam int unsigned JOB_BYTES     = 13;
    localparam int unsigned PAYLOAD_BYTES = JOB_BYTES - 1;
    localparam int unsigned HASH_W        = 24;
    localparam int unsigned NONCE_W       = 32;

    localparam logic [HASH_W-1:0] HASH_NONE = 24'hffffff;

endpackage

// File: rtl/hash_job_ctrl_job_byte_loader.sv
// Collects the 13-byte job (12 payload bytes MSB-first, then target) from a valid/ready stream.
module hash_job_ctrl_job_byte_loader
    import hash_job_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [7:0]                 in_byte,
    output logic                       in_ready,
    output logic [PAYLOAD_BYTES*8-1:0] payload,
    output logic [7:0]                 target,
    output logic                       job_loaded
);

    logic                       live_q;
    logic                       loaded_q;
    logic [3:0]                 byte_cnt_q;
    logic [PAYLOAD_BYTES*8-1:0] payload_q;
    logic [7:0]                 target_q;
    logic                       accept;

    // live_q keeps in_ready low while reset is held and for the release cycle;
    // loaded_q blocks bytes in the hand-off cycle before the FSM leaves IDLE.
    assign in_ready   = live_q & enable & ~loaded_q;
    assign accept     = in_valid & in_ready;
    assign payload    = payload_q;
    assign target     = target_q;
    assign job_loaded = loaded_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q     <= 1'b0;
            loaded_q   <= 1'b0;
            byte_cnt_q <= 4'd0;
            payload_q  <= '0;
            target_q   <= 8'd0;
        end else begin
            live_q   <= 1'b1;
            loaded_q <= 1'b0;
            if (accept) begin
                if (byte_cnt_q == 4'(JOB_BYTES - 1)) begin
                    target_q   <= in_byte;
                    byte_cnt_q <= 4'd0;
                    loaded_q   <= 1'b1;
                end else begin
                    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
                        if (byte_cnt_q == 4'(i)) begin
                            payload_q[PAYLOAD_BYTES*8-1-8*i -: 8] <= in_byte;
                        end
                    end
                    byte_cnt_q <= byte_cnt_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/hash_job_ctrl.sv
// Job loader / result collector wrapped around the hasher: load, run with timeout, report, clear.
module hash_job_ctrl
    import hash_job_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES    = 2000,
    parameter int unsigned IGNORE_CYCLES = 2,
    parameter int unsigned CYC_W         = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_byte,
    output logic                       job_active,
    output logic [PAYLOAD_BYTES*8-1:0] job_payload,
    output logic [7:0]                 job_target,
    input  logic                       hash_done,
    input  logic [NONCE_W-1:0]         hash_nonce,
    input  logic [HASH_W-1:0]          hash_value,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_found,
    output logic [NONCE_W-1:0]         res_nonce,
    output logic [HASH_W-1:0]          res_hash,
    output logic [CYC_W-1:0]           res_cycles,
    output logic                       busy
);

    state_e               state_q, state_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d, cyc_inc;
    logic                 found_q, found_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [HASH_W-1:0]    hash_q, hash_d;
    logic [CYC_W-1:0]     cycles_q, cycles_d;
    logic                 job_loaded;

    hash_job_ctrl_job_byte_loader u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state_q == S_IDLE),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .payload    (job_payload),
        .target     (job_target),
        .job_loaded (job_loaded)
    );

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        found_d  = found_q;
        nonce_d  = nonce_q;
        hash_d   = hash_q;
        cycles_d = cycles_q;
        cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);

        case (state_q)
            S_IDLE: begin
                if (job_loaded) begin
                    cyc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // cyc_inc is the 1-based index of the current RUN cycle.
                cyc_d = cyc_inc;
                if (hash_done && (cyc_inc > CYC_W'(IGNORE_CYCLES))) begin
                    found_d  = 1'b1;
                    nonce_d  = hash_nonce;
                    hash_d   = hash_value;
                    cycles_d = cyc_inc;
                    state_d  = S_DONE;
                end else if (cyc_inc >= CYC_W'(MAX_CYCLES)) begin
                    found_d  = 1'b0;
                    nonce_d  = '0;
                    hash_d   = HASH_NONE;
                    cycles_d = cyc_inc;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            found_q  <= 1'b0;
            nonce_q  <= '0;
            hash_q   <= HASH_NONE;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            found_q  <= found_d;
            nonce_q  <= nonce_d;
            hash_q   <= hash_d;
            cycles_q <= cycles_d;
        end
    end

    // DONE keeps the hasher active so its latched outputs stay put; CLEAR drops it for one cycle.
    assign job_active = (state_q == S_RUN) || (state_q == S_DONE);
    assign res_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign res_found  = found_q;
    assign res_nonce  = nonce_q;
    assign res_hash   = hash_q;
    assign res_cycles = cycles_q;

endmodule
